// File: rtl/bus_pkg.sv
// Shared definitions for the register-bus initiator.
// Holds the bus widths, the error data word and the FSM state type.
package bus_pkg;

    localparam int unsigned BUS_ADDR_W = 24;
    localparam int unsigned BUS_DATA_W = 32;
    localparam int unsigned BUS_STRB_W = 4;

    localparam logic [BUS_DATA_W-1:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } bus_init_state_t;

    // Reads carry no byte enables on the bus; writes pass the command's.
    function automatic logic [BUS_STRB_W-1:0] bus_strb_for(
        input logic                  is_write,
        input logic [BUS_STRB_W-1:0] strb
    );
        return is_write ? strb : '0;
    endfunction

    // Reads carry no write data on the bus.
    function automatic logic [BUS_DATA_W-1:0] bus_wdata_for(
        input logic                  is_write,
        input logic [BUS_DATA_W-1:0] wdata
    );
        return is_write ? wdata : '0;
    endfunction

endpackage

// File: rtl/bus_initiator.sv
// Single-outstanding register-bus initiator.
// Accepts one command, drives it onto the subsystem bus until the responder
// acknowledges, then holds the response until it is consumed.
// Optional feature macro: BUS_INITIATOR_TIMEOUT_EN adds a wait counter that
// aborts a stalled bus request after TIMEOUT_CYCLES cycles with an error.
module bus_initiator
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  sys_clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [BUS_ADDR_W-1:0] cmd_addr,
    input  logic [BUS_DATA_W-1:0] cmd_wdata,
    input  logic [BUS_STRB_W-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BUS_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_error,

    output logic                  bus_valid,
    output logic [BUS_ADDR_W-1:0] bus_addr,
    output logic                  bus_write,
    output logic [BUS_DATA_W-1:0] bus_wdata,
    output logic [BUS_STRB_W-1:0] bus_wstrb,
    input  logic [BUS_DATA_W-1:0] bus_rdata,
    input  logic                  bus_ready
);

    bus_init_state_t       state_q, state_d;

    logic                  bus_valid_q, bus_valid_d;
    logic [BUS_ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic                  bus_write_q, bus_write_d;
    logic [BUS_DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [BUS_STRB_W-1:0] bus_wstrb_q, bus_wstrb_d;

    logic                  rsp_valid_q, rsp_valid_d;
    logic [BUS_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic                  cmd_take;

`ifdef BUS_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0]           wait_q, wait_d;
    logic                  rsp_error_q, rsp_error_d;
    logic                  timeout_hit;

    // The counter holds the number of REQ edges already spent without
    // bus_ready, so the edge that would make it reach the limit aborts.
    assign timeout_hit = (wait_q == WAIT_LAST);
    assign rsp_error   = rsp_error_q;
`else
    assign rsp_error   = 1'b0;
`endif

    // Held low during reset so no command can be offered into a clearing FSM.
    assign cmd_ready = (state_q == IDLE) && !rst;
    assign cmd_take  = cmd_valid && cmd_ready;

    assign bus_valid = bus_valid_q;
    assign bus_addr  = bus_addr_q;
    assign bus_write = bus_write_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    // Next-state and next-register computation; everything holds unless the
    // current state has a reason to change it.
    always_comb begin
        state_d     = state_q;
        bus_valid_d = bus_valid_q;
        bus_addr_d  = bus_addr_q;
        bus_write_d = bus_write_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef BUS_INITIATOR_TIMEOUT_EN
        wait_d      = wait_q;
        rsp_error_d = rsp_error_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (cmd_take) begin
                    bus_valid_d = 1'b1;
                    bus_addr_d  = cmd_addr;
                    bus_write_d = cmd_write;
                    bus_wdata_d = bus_wdata_for(cmd_write, cmd_wdata);
                    bus_wstrb_d = bus_strb_for(cmd_write, cmd_wstrb);
`ifdef BUS_INITIATOR_TIMEOUT_EN
                    wait_d      = '0;
`endif
                    state_d     = REQ;
                end
            end

            REQ: begin
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus_write_q ? '0 : bus_rdata;
`ifdef BUS_INITIATOR_TIMEOUT_EN
                    rsp_error_d = 1'b0;
`endif
                    state_d     = RESP;
                end
`ifdef BUS_INITIATOR_TIMEOUT_EN
                else if (timeout_hit) begin
                    bus_valid_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = BUS_ERR_DATA;
                    rsp_error_d = 1'b1;
                    wait_d      = wait_q + 16'd1;
                    state_d     = RESP;
                end else begin
                    wait_d      = wait_q + 16'd1;
                end
`endif
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                bus_valid_d = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and capture registers; reset drops any transaction in flight.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_write_q <= 1'b0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_valid_q <= bus_valid_d;
            bus_addr_q  <= bus_addr_d;
            bus_write_q <= bus_write_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef BUS_INITIATOR_TIMEOUT_EN
    // Wait counter and error flag exist only when the abort feature is built.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wait_q      <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            wait_q      <= wait_d;
            rsp_error_q <= rsp_error_d;
        end
    end
`endif

endmodule

// File: tb/tb_bus_initiator.sv
// Directed testbench for bus_initiator: reset values, write with a stalled
// responder, minimum-latency read, response back-pressure, reset mid-request,
// back-to-back throughput and (when built) the request timeout.
module tb_bus_initiator;

`ifdef BUS_INITIATOR_TIMEOUT_EN
    localparam int unsigned TbTimeout = 8;
`else
    localparam int unsigned TbTimeout = 256;
`endif

    logic        sys_clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [23:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        bus_valid;
    logic [23:0] bus_addr;
    logic        bus_write;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    int checks;
    int errors;
    int rspCount;

    bus_initiator #(.TIMEOUT_CYCLES(TbTimeout)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .bus_valid (bus_valid),
        .bus_addr  (bus_addr),
        .bus_write (bus_write),
        .bus_wdata (bus_wdata),
        .bus_wstrb (bus_wstrb),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready)
    );

    // 10-unit clock period.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Advance one edge and settle just after it before sampling.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Drive one command onto the command port.
    task automatic applyStimulus(input logic valid, input logic write,
                                 input logic [23:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb);
        cmd_valid = valid;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = strb;
    endtask

    // Compare one observed value with the bench's expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Directed sequence.
    initial begin
        checks    = 0;
        errors    = 0;
        rspCount  = 0;
        rst       = 1'b1;
        rsp_ready = 1'b0;
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        applyStimulus(1'b0, 1'b0, 24'h0, 32'h0, 4'h0);

        // Reset values
        #2;
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst_bus_valid", 32'(bus_valid), 32'd0);
        checkOutput("rst_bus_write", 32'(bus_write), 32'd0);
        checkOutput("rst_bus_addr",  32'(bus_addr),  32'd0);
        checkOutput("rst_bus_wdata", bus_wdata,      32'd0);
        checkOutput("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata,      32'd0);
        checkOutput("rst_rsp_error", 32'(rsp_error), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // bus_ready while idle must not create a response
        bus_ready = 1'b1;
        tick();
        checkOutput("idle_ready_ignored", 32'(rsp_valid), 32'd0);
        bus_ready = 1'b0;

        // Write with responder ready after 3 REQ cycles
        bus_rdata = 32'h1234_5678;
        applyStimulus(1'b1, 1'b1, 24'h000010, 32'h0000_000F, 4'hF);
        tick();
        applyStimulus(1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("wr_bus_valid", 32'(bus_valid), 32'd1);
            checkOutput("wr_bus_addr",  32'(bus_addr),  32'h10);
            checkOutput("wr_bus_write", 32'(bus_write), 32'd1);
            checkOutput("wr_bus_wdata", bus_wdata,      32'hF);
            checkOutput("wr_bus_wstrb", 32'(bus_wstrb), 32'hF);
            checkOutput("wr_cmd_ready", 32'(cmd_ready), 32'd0);
            if (i == 2) bus_ready = 1'b1;
            tick();
        end
        bus_ready = 1'b0;
        checkOutput("wr_bus_valid_drop", 32'(bus_valid), 32'd0);
        checkOutput("wr_rsp_valid",      32'(rsp_valid), 32'd1);
        checkOutput("wr_rsp_rdata",      rsp_rdata,      32'd0);
        checkOutput("wr_rsp_error",      32'(rsp_error), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("wr_rsp_done",  32'(rsp_valid), 32'd0);
        checkOutput("wr_cmd_ready_back", 32'(cmd_ready), 32'd1);

        // Minimum-latency read
        applyStimulus(1'b1, 1'b0, 24'h000004, 32'hFFFF_FFFF, 4'hF);
        tick();
        applyStimulus(1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
        checkOutput("rd_bus_valid", 32'(bus_valid), 32'd1);
        checkOutput("rd_bus_write", 32'(bus_write), 32'd0);
        checkOutput("rd_bus_addr",  32'(bus_addr),  32'h4);
        checkOutput("rd_bus_wstrb", 32'(bus_wstrb), 32'd0);
        checkOutput("rd_bus_wdata", bus_wdata,      32'd0);
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_0005;
        tick();
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rd_rsp_rdata", rsp_rdata,      32'h5);
        checkOutput("rd_bus_valid_drop", 32'(bus_valid), 32'd0);

        // Response back-pressure with a second command waiting
        applyStimulus(1'b1, 1'b1, 24'h000020, 32'hA5A5_A5A5, 4'h3);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rsp_rdata", rsp_rdata,      32'h5);
            checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            checkOutput("bp_bus_valid", 32'(bus_valid), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("bp_rsp_done",      32'(rsp_valid), 32'd0);
        checkOutput("bp_not_yet_taken", 32'(bus_valid), 32'd0);
        checkOutput("bp_cmd_ready_back", 32'(cmd_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
        checkOutput("bp_second_valid", 32'(bus_valid), 32'd1);
        checkOutput("bp_second_addr",  32'(bus_addr),  32'h20);
        checkOutput("bp_second_wstrb", 32'(bus_wstrb), 32'h3);
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        checkOutput("bp_second_rsp", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset pulse mid-REQ
        applyStimulus(1'b1, 1'b1, 24'h000030, 32'h1111_2222, 4'hC);
        tick();
        applyStimulus(1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
        checkOutput("mr_bus_valid_pre", 32'(bus_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mr_bus_valid", 32'(bus_valid), 32'd0);
        checkOutput("mr_bus_addr",  32'(bus_addr),  32'd0);
        checkOutput("mr_bus_wdata", bus_wdata,      32'd0);
        checkOutput("mr_bus_wstrb", 32'(bus_wstrb), 32'd0);
        checkOutput("mr_bus_write", 32'(bus_write), 32'd0);
        checkOutput("mr_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        rst = 1'b0;
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        checkOutput("mr_no_rsp",      32'(rsp_valid), 32'd0);
        checkOutput("mr_no_bus",      32'(bus_valid), 32'd0);
        checkOutput("mr_cmd_ready_1", 32'(cmd_ready), 32'd1);
        applyStimulus(1'b1, 1'b0, 24'h000008, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
        checkOutput("mr_next_addr", 32'(bus_addr), 32'h8);
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_0009;
        tick();
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        checkOutput("mr_next_rsp",   32'(rsp_valid), 32'd1);
        checkOutput("mr_next_rdata", rsp_rdata,      32'h9);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Long stall: default build waits; timeout build aborts after 8
`ifdef BUS_INITIATOR_TIMEOUT_EN
        applyStimulus(1'b1, 1'b0, 24'h000040, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("to_bus_valid", 32'(bus_valid), 32'd1);
            tick();
        end
        checkOutput("to_bus_valid_drop", 32'(bus_valid), 32'd0);
        checkOutput("to_rsp_valid",      32'(rsp_valid), 32'd1);
        checkOutput("to_rsp_error",      32'(rsp_error), 32'd1);
        checkOutput("to_rsp_rdata",      rsp_rdata,      32'hDEAD_BEEF);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Ready on the limit edge: completion wins
        applyStimulus(1'b1, 1'b0, 24'h000044, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                bus_ready = 1'b1;
                bus_rdata = 32'h0000_0077;
            end
            tick();
        end
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        checkOutput("lim_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("lim_rsp_error", 32'(rsp_error), 32'd0);
        checkOutput("lim_rsp_rdata", rsp_rdata,      32'h77);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`else
        applyStimulus(1'b1, 1'b0, 24'h000040, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
        for (int i = 0; i < 20; i++) tick();
        checkOutput("stall_bus_valid", 32'(bus_valid), 32'd1);
        checkOutput("stall_rsp_valid", 32'(rsp_valid), 32'd0);
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_0066;
        tick();
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        checkOutput("stall_rsp_rdata", rsp_rdata,      32'h66);
        checkOutput("stall_rsp_error", 32'(rsp_error), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif

        // Back-to-back: one transaction every 3 cycles
        checkOutput("b2b_start_idle", 32'(cmd_ready), 32'd1);
        applyStimulus(1'b1, 1'b1, 24'h000050, 32'hCAFE_F00D, 4'hF);
        rsp_ready = 1'b1;
        bus_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            checkOutput("b2b_bus_valid", 32'(bus_valid), ((i % 3) == 0) ? 32'd1 : 32'd0);
            if (rsp_valid) rspCount++;
        end
        applyStimulus(1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
        rsp_ready = 1'b0;
        bus_ready = 1'b0;
        checkOutput("b2b_rsp_count", 32'(rspCount), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, max cycles waiting for bus_ready before abort (range 2..65535).
REQ-002 sys_clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready at edge.
REQ-006 cmd_write  input  1  1=write, 0=read.
REQ-007 cmd_addr  input  24  byte address.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 cmd_wstrb  input  4  byte enables.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed when rsp_valid&&rsp_ready at edge.
REQ-012 rsp_rdata  output  32  read data (0 for writes).
REQ-013 rsp_error  output  1  transaction timed out.
REQ-014 bus_valid, bus_addr[23:0], bus_write, bus_wdata[31:0], bus_wstrb[3:0]  output  initiator side of the subsystem register bus.
REQ-015 bus_rdata  input  32; bus_ready  input  1  responder side.

Function
REQ-016 FSM states IDLE, REQ, RESP only.
REQ-017 IDLE: cmd_ready=1; on cmd handshake, register cmd fields onto bus_* and go REQ next cycle with bus_valid=1.
REQ-018 REQ: bus_valid=1, bus_addr/write/wdata/wstrb held stable until completion.
REQ-019 Completion = bus_valid&&bus_ready at an edge; capture bus_rdata (reads) or 0 (writes), rsp_error=0, bus_valid=0 next cycle, go RESP.
REQ-020 Writes drive bus_wstrb=cmd_wstrb; reads drive bus_wstrb=4'h0 and bus_wdata=0.
REQ-021 Wait counter 16 bits, cleared on REQ entry, increments each REQ cycle without bus_ready.
REQ-022 RESP: rsp_valid=1 with rsp_rdata/rsp_error stable until rsp_ready; on handshake go IDLE, rsp_valid=0 next cycle.
REQ-023 cmd_ready=0 in REQ and RESP; single outstanding transaction.
REQ-024 Minimum latency: cmd handshake at edge N, bus_valid high from N, bus_ready at N+1 -> rsp_valid high after edge N+1.
REQ-025 bus_ready while bus_valid=0 ignored.
REQ-026 bus_ready sampled at same edge counter reaches limit: completion wins, no error.

Reset
REQ-027 rst asserted: state=IDLE, counter=0 immediately, asynchronously.
REQ-028 Reset values: cmd_ready=0 while rst high, 1 first cycle after release; bus_valid=0, bus_write=0, bus_addr=0, bus_wdata=0, bus_wstrb=0, rsp_valid=0, rsp_rdata=0, rsp_error=0.
REQ-029 Reset mid-REQ or mid-RESP drops transaction silently; no response emitted after release.

Configuration
REQ-030 Macro BUS_INITIATOR_TIMEOUT_EN defined: counter reaching TIMEOUT_CYCLES in REQ -> bus_valid=0 next cycle, rsp_rdata=32'hDEAD_BEEF, rsp_error=1, go RESP.
REQ-031 Macro undefined: no counter logic, REQ waits indefinitely, rsp_error tied 0.

Structure
REQ-032 Package bus_pkg holds BUS_ADDR_W=24, BUS_DATA_W=32, BUS_STRB_W=4, BUS_ERR_DATA=32'hDEAD_BEEF, state enum bus_init_state_t.
REQ-033 No sub-module; FSM, capture registers and counter flat in bus_initiator.

Verification
REQ-034 Write addr 24'h000010 data 32'h0000_000F strb 4'hF, responder ready after 3 cycles -> bus fields stable 3 cycles, rsp_valid with rdata 0, error 0.
REQ-035 Read addr 24'h000004, responder returns 32'h0000_0005 same cycle as ready -> rsp_rdata=32'h0000_0005, bus_wstrb=0 during REQ.
REQ-036 With BUS_INITIATOR_TIMEOUT_EN, TIMEOUT_CYCLES=8, responder never ready -> bus_valid drops after 8 REQ cycles, rsp_error=1, rsp_rdata=32'hDEAD_BEEF.
REQ-037 rsp_ready held low 5 cycles -> rsp_valid/rdata stable, cmd_ready=0, second cmd_valid not accepted until response consumed.
REQ-038 rst pulsed 1 cycle mid-REQ -> all outputs at reset values during rst, no rsp_valid afterwards, next command completes normally.
REQ-039 Back-to-back: rsp_ready tied 1, cmd_valid tied 1 -> one transaction per 3 cycles minimum, bus_valid low at least 1 cycle between transactions.
